// File: rtl/demux_1_to_2_stream_pkg.sv
// Shared datapath definitions for the 1-to-2 stream demultiplexer.
package demux_1_to_2_stream_pkg;

  // Datapath word width shared with the rest of the pipeline.
  localparam int WORD_WIDTH = 16;

  // Select encodings: which consumer stream receives the word.
  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

  // Default per-output buffering.
  localparam int FIFO_DEPTH = 2;

endpackage : demux_1_to_2_stream_pkg

// File: rtl/demux_1_to_2_stream_fifo.sv
// Small synchronous FIFO used as the per-output buffer of the demux.
// Head word is presented from storage (no same-cycle bypass); head reads 0 while empty.
module demux_1_to_2_stream_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  output logic                       o_full,
  input  logic                       i_pop,
  output logic                       o_empty,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic             w_full;
  logic             w_empty;
  logic             w_push_en;
  logic             w_pop_en;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == {CW{1'b0}});
  // A push into a full buffer or a pop from an empty one is ignored.
  assign w_push_en = i_push && !w_full;
  assign w_pop_en  = i_pop && !w_empty;

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push_en) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop_en) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_en, w_pop_en})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head word, forced to zero while nothing is buffered.
  always_comb begin
    o_head = {WIDTH{1'b0}};
    if (w_empty) begin
      o_head = {WIDTH{1'b0}};
    end else begin
      o_head = r_mem[r_rd_ptr];
    end
  end

  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;

endmodule : demux_1_to_2_stream_fifo

// File: rtl/demux_1_to_2_stream.sv
// 1-to-2 stream demultiplexer: one producer stream steered per word by in_select
// into one of two independently buffered consumer streams.
module demux_1_to_2_stream
  import demux_1_to_2_stream_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_select,
  output logic                   out0_valid,
  input  logic                   out0_ready,
  output logic [WIDTH-1:0]       out0_data,
  output logic                   out1_valid,
  input  logic                   out1_ready,
  output logic [WIDTH-1:0]       out1_data,
  output logic [$clog2(DEPTH):0] out0_count,
  output logic [$clog2(DEPTH):0] out1_count
);

  logic w_full0;
  logic w_full1;
  logic w_empty0;
  logic w_empty1;
  logic w_accept;
  logic w_push0;
  logic w_push1;

  // Ready depends only on the selected buffer's registered fullness, never on a
  // same-cycle pop, so a word aimed at a full buffer waits one cycle.
  always_comb begin
    in_ready = 1'b0;
    if (in_select == SEL_OUT1) begin
      in_ready = !w_full1;
    end else begin
      in_ready = !w_full0;
    end
  end

  assign w_accept = in_valid && in_ready;
  assign w_push0  = w_accept && (in_select == SEL_OUT0);
  assign w_push1  = w_accept && (in_select == SEL_OUT1);

  demux_1_to_2_stream_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push0),
    .i_push_data (in_data),
    .o_full      (w_full0),
    .i_pop       (out0_ready),
    .o_empty     (w_empty0),
    .o_head      (out0_data),
    .o_count     (out0_count)
  );

  demux_1_to_2_stream_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push1),
    .i_push_data (in_data),
    .o_full      (w_full1),
    .i_pop       (out1_ready),
    .o_empty     (w_empty1),
    .o_head      (out1_data),
    .o_count     (out1_count)
  );

  assign out0_valid = !w_empty0;
  assign out1_valid = !w_empty1;

endmodule : demux_1_to_2_stream

// File: tb/tb_demux_1_to_2_stream.sv
// Directed self-checking bench for demux_1_to_2_stream (WIDTH=16, DEPTH=2).
module tb_demux_1_to_2_stream;
  import demux_1_to_2_stream_pkg::*;

  logic                  clk;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [WORD_WIDTH-1:0] in_data;
  logic                  in_select;
  logic                  out0_valid;
  logic                  out0_ready;
  logic [WORD_WIDTH-1:0] out0_data;
  logic                  out1_valid;
  logic                  out1_ready;
  logic [WORD_WIDTH-1:0] out1_data;
  logic [1:0]            out0_count;
  logic [1:0]            out1_count;

  int n_checks;
  int n_errors;

  demux_1_to_2_stream #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_select  (in_select),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out0_count (out0_count),
    .out1_count (out1_count)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle past the edge before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 16'd0;
    in_select  = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;

    // 1. Reset for two cycles.
    step();
    step();
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out0_valid", 32'(out0_valid), 32'd0);
    check_eq("rst_out1_valid", 32'(out1_valid), 32'd0);
    check_eq("rst_out0_count", 32'(out0_count), 32'd0);
    check_eq("rst_out1_count", 32'(out1_count), 32'd0);
    check_eq("rst_out0_data", 32'(out0_data), 32'd0);
    rst_n = 1'b1;

    // 2. Steering with both consumers ready.
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    in_valid   = 1'b1;
    in_data    = 16'd123;
    in_select  = 1'b0;
    #1;
    check_eq("steer_ready0", 32'(in_ready), 32'd1);
    check_eq("steer_nobypass", 32'(out0_valid), 32'd0);
    step();
    check_eq("steer_out0_valid", 32'(out0_valid), 32'd1);
    check_eq("steer_out0_data", 32'(out0_data), 32'd123);
    check_eq("steer_out1_idle", 32'(out1_valid), 32'd0);
    in_data   = 16'd456;
    in_select = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("steer_out0_gone", 32'(out0_valid), 32'd0);
    check_eq("steer_out1_valid", 32'(out1_valid), 32'd1);
    check_eq("steer_out1_data", 32'(out1_data), 32'd456);
    step();
    check_eq("steer_out1_gone", 32'(out1_valid), 32'd0);

    // 3. Backpressure on output0.
    out0_ready = 1'b0;
    in_valid   = 1'b1;
    in_select  = 1'b0;
    in_data    = 16'd1;
    step();
    in_data = 16'd2;
    #1;
    check_eq("bp_ready_2", 32'(in_ready), 32'd1);
    step();
    in_data = 16'd3;
    #1;
    check_eq("bp_stall_3", 32'(in_ready), 32'd0);
    check_eq("bp_count_full", 32'(out0_count), 32'd2);
    check_eq("bp_head_1", 32'(out0_data), 32'd1);
    step();
    check_eq("bp_still_stalled", 32'(in_ready), 32'd0);
    check_eq("bp_hold_data", 32'(out0_data), 32'd1);
    out0_ready = 1'b1;
    #1;
    check_eq("bp_no_pop_bypass", 32'(in_ready), 32'd0);
    step();
    check_eq("bp_head_2", 32'(out0_data), 32'd2);
    check_eq("bp_count_after_pop", 32'(out0_count), 32'd1);
    check_eq("bp_ready_after_pop", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check_eq("bp_head_3", 32'(out0_data), 32'd3);
    check_eq("bp_count_pushpop", 32'(out0_count), 32'd1);
    step();
    check_eq("bp_drained", 32'(out0_count), 32'd0);
    check_eq("bp_drained_data", 32'(out0_data), 32'd0);

    // 4. Isolation: output0 full and stalled, output1 still accepts.
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    in_valid   = 1'b1;
    in_select  = 1'b0;
    in_data    = 16'd10;
    step();
    in_data = 16'd11;
    step();
    in_select = 1'b1;
    in_data   = 16'd7;
    #1;
    check_eq("iso_ready_out1", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check_eq("iso_out1_valid", 32'(out1_valid), 32'd1);
    check_eq("iso_out1_data", 32'(out1_data), 32'd7);
    check_eq("iso_out0_count", 32'(out0_count), 32'd2);
    check_eq("iso_out0_head", 32'(out0_data), 32'd10);
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    step();
    check_eq("iso_out0_next", 32'(out0_data), 32'd11);
    check_eq("iso_out1_empty", 32'(out1_count), 32'd0);
    step();
    check_eq("iso_out0_empty", 32'(out0_count), 32'd0);

    // 5. Streaming 0..9 through output1 with wrap and simultaneous push/pop.
    in_valid  = 1'b1;
    in_select = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 16'(i);
      step();
      check_eq("wrap_data", 32'(out1_data), 32'(i));
      check_eq("wrap_count", 32'(out1_count), 32'd1);
    end
    in_valid = 1'b0;
    step();
    check_eq("wrap_final_count", 32'(out1_count), 32'd0);

    // 6. Reset mid-operation discards buffered words.
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    in_valid   = 1'b1;
    in_select  = 1'b0;
    in_data    = 16'd20;
    step();
    in_data = 16'd21;
    step();
    in_select = 1'b1;
    in_data   = 16'd30;
    step();
    in_data = 16'd31;
    step();
    check_eq("mid_count0", 32'(out0_count), 32'd2);
    check_eq("mid_count1", 32'(out1_count), 32'd2);
    rst_n     = 1'b0;
    in_select = 1'b0;
    in_data   = 16'd55;
    step();
    check_eq("mid_rst_count0", 32'(out0_count), 32'd0);
    check_eq("mid_rst_count1", 32'(out1_count), 32'd0);
    check_eq("mid_rst_valid0", 32'(out0_valid), 32'd0);
    check_eq("mid_rst_valid1", 32'(out1_valid), 32'd0);
    rst_n      = 1'b1;
    in_data    = 16'd99;
    out0_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("mid_first_word", 32'(out0_data), 32'd99);
    check_eq("mid_first_count", 32'(out0_count), 32'd1);
    step();
    check_eq("mid_end_count", 32'(out0_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_demux_1_to_2_stream
